// File: rtl/seg_capture_decoder.sv
// Display monitor: samples the multiplexed active-low 7-segment bus and anodes,
// waits for a stable pattern per digit, and decodes it back to a 4-bit code.
module seg_capture_decoder #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:7]  seginvert,
    input  logic [3:0]  an,
    output logic [15:0] codes,
    output logic [3:0]  valid,
    output logic        update,
    output logic        err,
    output logic [1:0]  err_digit
);

    localparam logic [3:0]  RUN_LAST = 4'(STABLE_CNT - 1);
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_LATCHED
    } state_t;

    state_t      r_state;
    logic [1:7]  r_seg_smp;
    logic [3:0]  r_an_smp;
    logic [1:7]  r_prev_seg;
    logic [3:0]  r_prev_an;
    logic [3:0]  r_run;
    logic        r_update;
    logic        r_err;
    logic [1:0]  r_err_digit;
    logic [15:0] r_codes;
    logic [3:0]  r_valid;
    logic [15:0] r_refresh [4];

    logic [1:7]  w_seg;
    logic        w_legal;
    logic [1:0]  w_digit;
    logic        w_same;
    logic        w_glyph_ok;
    logic [3:0]  w_code;
    logic        w_latch;

    assign w_seg  = ~r_seg_smp;
    assign w_same = (r_seg_smp == r_prev_seg) && (r_an_smp == r_prev_an);

    always_comb begin
        w_legal = 1'b1;
        w_digit = 2'd0;
        case (r_an_smp)
            4'b1110: w_digit = 2'd0;
            4'b1101: w_digit = 2'd1;
            4'b1011: w_digit = 2'd2;
            4'b0111: w_digit = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_glyph_ok = 1'b1;
        w_code     = 4'h0;
        case (w_seg)
            7'b1111110: w_code = 4'h0;
            7'b0110000: w_code = 4'h1;
            7'b1101101: w_code = 4'h2;
            7'b1111001: w_code = 4'h3;
            7'b0110011: w_code = 4'h4;
            7'b1011011: w_code = 4'h5;
            7'b1011111: w_code = 4'h6;
            7'b1110000: w_code = 4'h7;
            7'b1111111: w_code = 4'h8;
            7'b1111011: w_code = 4'h9;
            7'b1110111: w_code = 4'hA;
            7'b0111110: w_code = 4'hB;
            7'b0001110: w_code = 4'hC;
            7'b0000000: w_code = 4'hF;
            default:    w_glyph_ok = 1'b0;
        endcase
    end

    // The run counter is incremented on the same edge that reaches STABLE_CNT,
    // so the latch fires when the previous count is STABLE_CNT-1.
    assign w_latch = (r_state == S_TRACK) && w_legal && w_same && (r_run == RUN_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg_smp <= '1;
            r_an_smp  <= '1;
        end else begin
            r_seg_smp <= seginvert;
            r_an_smp  <= an;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_prev_seg  <= '1;
            r_prev_an   <= '1;
            r_run       <= '0;
            r_update    <= 1'b0;
            r_err       <= 1'b0;
            r_err_digit <= '0;
        end else begin
            r_update <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_legal) begin
                        r_state    <= S_TRACK;
                        r_run      <= 4'd1;
                        r_prev_seg <= r_seg_smp;
                        r_prev_an  <= r_an_smp;
                    end
                end
                S_TRACK: begin
                    if (!w_legal) begin
                        r_state <= S_IDLE;
                        r_run   <= '0;
                    end else if (!w_same) begin
                        r_run      <= 4'd1;
                        r_prev_seg <= r_seg_smp;
                        r_prev_an  <= r_an_smp;
                    end else if (w_latch) begin
                        r_run   <= r_run + 4'd1;
                        r_state <= S_LATCHED;
                        if (w_glyph_ok) begin
                            r_update <= 1'b1;
                        end else begin
                            r_err       <= 1'b1;
                            r_err_digit <= w_digit;
                        end
                    end else begin
                        r_run <= r_run + 4'd1;
                    end
                end
                S_LATCHED: begin
                    if (!w_legal) begin
                        r_state <= S_IDLE;
                        r_run   <= '0;
                    end else if (!w_same) begin
                        r_state    <= S_TRACK;
                        r_run      <= 4'd1;
                        r_prev_seg <= r_seg_smp;
                        r_prev_an  <= r_an_smp;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_run   <= '0;
                end
            endcase
        end
    end

    // Per-digit code/valid and saturating refresh counters; a latch wins over timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_codes <= '0;
            r_valid <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_refresh[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_latch && w_glyph_ok && (w_digit == 2'(i))) begin
                    r_codes[4*i +: 4] <= w_code;
                    r_valid[i]        <= 1'b1;
                    r_refresh[i]      <= '0;
                end else if (r_refresh[i] != TO_LIMIT) begin
                    r_refresh[i] <= r_refresh[i] + 16'd1;
                    if (r_refresh[i] + 16'd1 == TO_LIMIT) begin
                        r_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign codes     = r_codes;
    assign valid     = r_valid;
    assign update    = r_update;
    assign err       = r_err;
    assign err_digit = r_err_digit;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Scoreboard bench for seg_capture_decoder: stimulus queues expected latch
// events, a negedge monitor pops and compares on every update/err pulse.
module tb_seg_capture_decoder;

    localparam int TO_CYC = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:7]  seginvert = '1;
    logic [3:0]  an = 4'hF;
    logic [15:0] codes;
    logic [3:0]  valid;
    logic        update;
    logic        err;
    logic [1:0]  err_digit;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        bit          is_err;
        int          digit;
        int          at_cyc;
        logic [15:0] codes;
    } ev_t;

    ev_t         q[$];
    logic [15:0] m_codes = '0;

    seg_capture_decoder #(
        .STABLE_CNT(4),
        .TIMEOUT(TO_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .seginvert(seginvert),
        .an(an),
        .codes(codes),
        .valid(valid),
        .update(update),
        .err(err),
        .err_digit(err_digit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: pattern becomes visible to the DUT at the next posedge.
    task automatic drive(input logic [3:0] a, input logic [6:0] pat);
        an        = a;
        seginvert = ~pat;
    endtask

    task automatic expect_upd(input int d, input logic [3:0] code);
        ev_t e;
        m_codes[4*d +: 4] = code;
        e = '{is_err: 1'b0, digit: d, at_cyc: cyc + 5, codes: m_codes};
        q.push_back(e);
    endtask

    task automatic expect_err(input int d);
        ev_t e;
        e = '{is_err: 1'b1, digit: d, at_cyc: cyc + 5, codes: m_codes};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && (update || err)) begin
            chk("upd_err_exclusive", {31'd0, update & err}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_event", {30'd0, update, err}, 32'd0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("event_cycle", cyc, e.at_cyc);
                chk("event_kind_err", {31'd0, err}, {31'd0, e.is_err});
                chk("event_codes", {16'd0, codes}, {16'd0, e.codes});
                if (e.is_err)
                    chk("err_digit", {30'd0, err_digit}, e.digit);
                else
                    chk("valid_bit", {31'd0, valid[e.digit]}, 32'd1);
            end
        end
    end

    initial begin
        int c;
        int lat;
        logic [6:0] rr_pat [4];
        rr_pat[0] = 7'b1110111;
        rr_pat[1] = 7'b0111110;
        rr_pat[2] = 7'b0001110;
        rr_pat[3] = 7'b0000000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_codes", {16'd0, codes}, 32'd0);
        chk("rst_valid", {28'd0, valid}, 32'd0);
        chk("rst_update", {31'd0, update}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_digit", {30'd0, err_digit}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Digit 0 shows "3", held 10 cycles: one update only
        drive(4'b1110, 7'b1111001);
        expect_upd(0, 4'h3);
        repeat (10) @(negedge clk);
        chk("t1_codes", {16'd0, codes}, 32'h0003);
        chk("t1_valid", {28'd0, valid}, 32'h1);

        // Round-robin letters and blank across all four digits
        for (int d = 0; d < 4; d++) begin
            drive(~(4'b0001 << d), rr_pat[d]);
            expect_upd(d, (d == 3) ? 4'hF : 4'(4'hA + d));
            repeat (6) @(negedge clk);
        end
        chk("t2_codes", {16'd0, codes}, 32'hFCBA);
        chk("t2_valid", {28'd0, valid}, 32'hF);

        // Invalid glyph on digit 1
        drive(4'b1101, 7'b1010101);
        expect_err(1);
        repeat (6) @(negedge clk);
        chk("t3_codes", {16'd0, codes}, 32'hFCBA);
        chk("t3_valid", {28'd0, valid}, 32'hF);
        chk("t3_err_digit", {30'd0, err_digit}, 32'd1);

        // Patterns too short to stabilise, then two anodes low
        for (int t = 0; t < 4; t++) begin
            drive(4'b1110, (t % 2 == 0) ? 7'b1111110 : 7'b0110000);
            repeat (3) @(negedge clk);
        end
        drive(4'b1100, 7'b1111001);
        repeat (8) @(negedge clk);
        chk("t4_codes", {16'd0, codes}, 32'hFCBA);
        chk("t4_valid", {28'd0, valid}, 32'hF);
        chk("t4_err_digit", {30'd0, err_digit}, 32'd1);

        // Timeout: latch digit 2 then stop driving it
        reset = 1'b1;
        drive(4'b1111, 7'b0000000);
        m_codes = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(4'b1011, 7'b1110000);
        expect_upd(2, 4'h7);
        lat = cyc + 5;
        repeat (6) @(negedge clk);
        drive(4'b1111, 7'b0000000);
        while (valid[2] && cyc < lat + 4 * TO_CYC) @(negedge clk);
        chk("t5_drop_cycle", cyc, lat + TO_CYC);
        chk("t5_codes_kept", {28'd0, codes[11:8]}, 32'h7);

        // Reset mid-run (run=3), then a full run is needed again
        @(negedge clk);
        drive(4'b0111, 7'b1111011);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_codes", {16'd0, codes}, 32'd0);
        chk("t6_rst_valid", {28'd0, valid}, 32'd0);
        chk("t6_rst_update", {31'd0, update}, 32'd0);
        chk("t6_rst_err", {31'd0, err}, 32'd0);
        m_codes = '0;
        @(negedge clk);
        reset = 1'b0;
        c = cyc;
        expect_upd(3, 4'h9);
        repeat (8) @(negedge clk);
        chk("t6_codes", {16'd0, codes}, 32'h9000);
        chk("t6_valid", {28'd0, valid}, 32'h8);
        chk("t6_elapsed", cyc - c, 32'd8);

        chk("pending_events", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_capture_decoder.md
Name: seg_capture_decoder

Overview:
Inverse of the alarm/clock segment encoders. Samples the multiplexed, active-low 7-segment bus and active-low digit anodes driven to the 4-digit display, and waits until each digit's pattern is stable. It then decodes the glyph back to a 4-bit code and holds a per-digit code/valid register. Used as an on-chip display monitor for self-check and readback of the alarm display path.

Parameters:
STABLE_CNT, 4, consecutive identical samples (same anode, same pattern) required before latching; legal range 2..15.
TIMEOUT, 65535, cycles without a successful latch after which a digit's valid bit clears; 16-bit counters.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
seginvert  input  [1:7]  active-low segments a..g (bit 1 = a); synchronous to clk
an  input  4  active-low digit enables; an[i]=0 selects digit i
codes  output  16  decoded codes; digit i at codes[4i+3:4i]
valid  output  4  valid[i]=1 when codes for digit i hold a live decode
update  output  1  one-cycle pulse when any digit latches a valid code
err  output  1  one-cycle pulse when a stable pattern is not in the glyph table
err_digit  output  2  index of the digit that caused the last err; holds until the next err

Behaviour:
- Input stage: seginvert and an are registered once per cycle as the sample. Internal pattern seg = ~sample.
- Sample is legal when exactly one an bit is 0. Zero or multiple low anodes are illegal.
- Glyph table (seg a..g -> code):
  - Digits: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Letters: A=1110111 -> 4'hA, U=0111110 -> 4'hB, L=0001110 -> 4'hC.
  - Blank 0000000 -> 4'hF.
  - Any other pattern is invalid.
- FSM:
  - IDLE: run=0. A legal sample -> TRACK with run=1.
  - TRACK: a sample equal to the previous one (same anode, same seg) increments run. When run reaches STABLE_CNT, latch and go to LATCHED. A changed legal sample restarts with run=1. An illegal sample -> IDLE.
  - LATCHED: no re-latch while the sample is unchanged. A changed legal sample -> TRACK with run=1. An illegal sample -> IDLE.
- Latch, when the pattern is in the table: codes[digit] <= code, valid[digit] <= 1, update = 1 for one cycle, refresh counter for that digit cleared.
- Latch, when the pattern is invalid: codes and valid for that digit unchanged, err = 1 for one cycle, err_digit <= digit index.
- Latency: a pattern present from the edge before k is first sampled at edge k. Outputs change at edge k+STABLE_CNT, which is 5 edges for the default.
- Timeout: each digit has a 16-bit refresh counter, saturating at TIMEOUT. When it reaches TIMEOUT, valid[i] <= 0 and codes[i] is held. A latch in the same cycle takes priority and sets valid.
- Anode change with an identical pattern counts as a change: run restarts at 1.
- update and err are never both 1; a single latch produces exactly one of them.
- Reset, asserted at any time, takes effect immediately regardless of clk:
  - codes=0, valid=0, update=0, err=0, err_digit=0.
  - Counters cleared, FSM in IDLE.
  - After release, a full STABLE_CNT run is needed before any latch.

Test Plan:
- an=1110, seginvert=~1111001 held 10 cycles -> codes[3:0]=3, valid=0001, update high exactly one cycle, 5 edges after first drive; no further update while held.
- Round-robin an=1110/1101/1011/0111, each held 6 cycles, with patterns 1110111, 0111110, 0001110, 0000000 -> codes=16'hFCBA, valid=1111, four update pulses.
- an=1101 with an invalid pattern 1010101 held 6 cycles -> err one-cycle pulse, err_digit=1, codes and valid unchanged.
- Pattern toggles every 3 cycles (shorter than STABLE_CNT); also an=1100 held -> no update, no err, outputs unchanged.
- Latch digit 2, then stop driving it (an=1111) -> valid[2] drops exactly TIMEOUT cycles after its latch; codes[11:8] retained.
- Assert reset mid-run (run=3) -> all outputs 0 immediately; after release the same stable pattern needs a full 4-sample run before update.
